// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: decodes received UART bytes into one-cycle command pulses and a validated set-time.
// Ports: clk; rst (async, active-low); rx_data/rx_done (byte and its strobe);
//   cmd_run/cmd_clear/cmd_mode/cmd_sr04/cmd_dht (command pulses); set_valid + set_hour/min/sec
//   (accepted time); cmd_err (malformed byte or sequence); busy (set-time sequence in progress).
// Macro UART_CMD_LOWERCASE_EN: when defined, lowercase command letters act as uppercase.
module uart_cmd_parser #(
  parameter int MAX_HOUR = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       cmd_run,
  output logic       cmd_clear,
  output logic       cmd_mode,
  output logic       cmd_sr04,
  output logic       cmd_dht,
  output logic       set_valid,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       cmd_err,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, DIGIT, TERM} state_t;
  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [5:0][3:0] dig_q, dig_d;
  // pulse vector: {err, valid, dht, sr04, mode, clear, run}
  logic [6:0]      p_q, p_d;
  logic [4:0]      hour_q, hour_d;
  logic [5:0]      min_q, min_d, sec_q, sec_d;
  logic            busy_q;
  logic [7:0]      c;
  logic            is_dig, is_eol, time_ok;
  logic [6:0]      hh, mm, ss;
`ifdef UART_CMD_LOWERCASE_EN
  // fold a-z onto A-Z; non-command letters still land on the error path
  assign c = (rx_data >= 8'h61 && rx_data <= 8'h7a) ? (rx_data & 8'hdf) : rx_data;
`else
  assign c = rx_data;
`endif
  assign is_dig  = rx_data >= 8'h30 && rx_data <= 8'h39;
  assign is_eol  = rx_data == 8'h0d || rx_data == 8'h0a;
  assign hh      = 7'(dig_q[0]) * 7'd10 + 7'(dig_q[1]);
  assign mm      = 7'(dig_q[2]) * 7'd10 + 7'(dig_q[3]);
  assign ss      = 7'(dig_q[4]) * 7'd10 + 7'(dig_q[5]);
  assign time_ok = hh <= 7'(MAX_HOUR) && mm <= 7'd59 && ss <= 7'd59;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dig_q   <= '0;
      p_q     <= '0;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      p_q     <= p_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      busy_q  <= state_d != IDLE;
    end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dig_d   = dig_q;
    if (rx_done)
      case (state_q)
        IDLE: if (c == 8'h53) begin
          state_d = DIGIT;
          idx_d   = '0;
        end
        DIGIT: if (is_dig) begin
          dig_d[idx_q] = rx_data[3:0];
          idx_d        = idx_q + 3'd1;
          state_d      = idx_q == 3'd5 ? TERM : DIGIT;
        end else begin
          state_d = IDLE;
          dig_d   = '0;
        end
        default: state_d = IDLE;
      endcase
  end
  always_comb begin
    p_d    = '0;
    hour_d = hour_q;
    min_d  = min_q;
    sec_d  = sec_q;
    if (rx_done)
      case (state_q)
        IDLE:
          case (c)
            8'h52:                      p_d = 7'h01;
            8'h43:                      p_d = 7'h02;
            8'h4d:                      p_d = 7'h04;
            8'h55:                      p_d = 7'h08;
            8'h44:                      p_d = 7'h10;
            8'h53, 8'h0d, 8'h0a, 8'h20: p_d = 7'h00;
            default:                    p_d = 7'h40;
          endcase
        DIGIT: p_d = is_dig ? 7'h00 : 7'h40;
        TERM: if (is_eol && time_ok) begin
          p_d    = 7'h20;
          hour_d = hh[4:0];
          min_d  = mm[5:0];
          sec_d  = ss[5:0];
        end else p_d = 7'h40;
        default: p_d = '0;
      endcase
  end
  assign {cmd_err, set_valid, cmd_dht, cmd_sr04, cmd_mode, cmd_clear, cmd_run} = p_q;
  assign set_hour = hour_q;
  assign set_min  = min_q;
  assign set_sec  = sec_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed self-checking bench for uart_cmd_parser.
module tb_uart_cmd_parser;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_done = 1'b0;
  logic       cmd_run, cmd_clear, cmd_mode, cmd_sr04, cmd_dht, set_valid, cmd_err, busy;
  logic [4:0] set_hour;
  logic [5:0] set_min, set_sec;
  logic [6:0] p;
  int         checks = 0;
  int         errors = 0;
  localparam logic [6:0] RUN = 7'h01, CLR = 7'h02, MODE = 7'h04, SR = 7'h08, DHT = 7'h10,
                         VAL = 7'h20, ERR = 7'h40, NONE = 7'h00;
  uart_cmd_parser dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .cmd_run(cmd_run), .cmd_clear(cmd_clear), .cmd_mode(cmd_mode), .cmd_sr04(cmd_sr04),
    .cmd_dht(cmd_dht), .set_valid(set_valid), .set_hour(set_hour), .set_min(set_min),
    .set_sec(set_sec), .cmd_err(cmd_err), .busy(busy)
  );
  always #5 clk = ~clk;
  assign p = {cmd_err, set_valid, cmd_dht, cmd_sr04, cmd_mode, cmd_clear, cmd_run};
  // drive one byte for a single cycle; on return the pulse for that byte is visible
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask
  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (p !== NONE) begin errors++; $display("FAIL reset_pulses got %h want %h", p, NONE); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if ({set_hour, set_min, set_sec} !== 17'd0) begin errors++; $display("FAIL reset_time got %0d:%0d:%0d want 0:0:0", set_hour, set_min, set_sec); end
    rst = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_commands;
    logic [7:0] bytes [9] = '{8'h52, 8'h43, 8'h4d, 8'h55, 8'h44, 8'h0d, 8'h0a, 8'h20, 8'h58};
    logic [6:0] exp   [9] = '{RUN, CLR, MODE, SR, DHT, NONE, NONE, NONE, ERR};
    for (int i = 0; i < 9; i++) begin
      send(bytes[i]);
      checks++; if (p !== exp[i]) begin errors++; $display("FAIL cmd_%h got %h want %h", bytes[i], p, exp[i]); end
      @(negedge clk);
      checks++; if (p !== NONE) begin errors++; $display("FAIL cmd_%h_width got %h want %h", bytes[i], p, NONE); end
    end
  endtask
  task automatic test_lowercase;
    logic [6:0] e;
`ifdef UART_CMD_LOWERCASE_EN
    e = RUN;
`else
    e = ERR;
`endif
    send(8'h72);
    checks++; if (p !== e) begin errors++; $display("FAIL lower_r got %h want %h", p, e); end
  endtask
  task automatic test_set_time;
    send(8'h53);
    checks++; if (busy !== 1'b1 || p !== NONE) begin errors++; $display("FAIL set_s busy %b pulses %h want 1 %h", busy, p, NONE); end
    send_str("12345");
    send(8'h36);
    checks++; if (busy !== 1'b1 || p !== NONE) begin errors++; $display("FAIL set_digits busy %b pulses %h want 1 %h", busy, p, NONE); end
    send(8'h0d);
    checks++; if (p !== VAL) begin errors++; $display("FAIL set_valid got %h want %h", p, VAL); end
    checks++; if ({set_hour, set_min, set_sec} !== {5'd12, 6'd34, 6'd56}) begin errors++; $display("FAIL set_time got %0d:%0d:%0d want 12:34:56", set_hour, set_min, set_sec); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL set_busy_end got %b want 0", busy); end
  endtask
  task automatic test_range;
    send_str("S245959");
    send(8'h0d);
    checks++; if (p !== ERR) begin errors++; $display("FAIL range_hour got %h want %h", p, ERR); end
    checks++; if ({set_hour, set_min, set_sec} !== {5'd12, 6'd34, 6'd56}) begin errors++; $display("FAIL range_hold got %0d:%0d:%0d want 12:34:56", set_hour, set_min, set_sec); end
    send_str("S235960");
    send(8'h0d);
    checks++; if (p !== ERR) begin errors++; $display("FAIL range_sec got %h want %h", p, ERR); end
    send_str("S236059");
    send(8'h0a);
    checks++; if (p !== ERR) begin errors++; $display("FAIL range_min got %h want %h", p, ERR); end
    send_str("S235959");
    send(8'h0a);
    checks++; if (p !== VAL || {set_hour, set_min, set_sec} !== {5'd23, 6'd59, 6'd59}) begin errors++; $display("FAIL range_max got %h %0d:%0d:%0d want %h 23:59:59", p, set_hour, set_min, set_sec, VAL); end
  endtask
  task automatic test_digit_err;
    send_str("S12");
    send(8'h41);
    checks++; if (p !== ERR || busy !== 1'b0) begin errors++; $display("FAIL digit_err got %h busy %b want %h busy 0", p, busy, ERR); end
    send(8'h43);
    checks++; if (p !== CLR) begin errors++; $display("FAIL digit_err_clear got %h want %h", p, CLR); end
    send_str("S123456");
    send(8'h58);
    checks++; if (p !== ERR || busy !== 1'b0) begin errors++; $display("FAIL term_err got %h busy %b want %h busy 0", p, busy, ERR); end
    checks++; if ({set_hour, set_min, set_sec} !== {5'd23, 6'd59, 6'd59}) begin errors++; $display("FAIL term_err_hold got %0d:%0d:%0d want 23:59:59", set_hour, set_min, set_sec); end
  endtask
  task automatic test_back_to_back;
    string s = "RUCS010203";
    logic [6:0] exp [10] = '{RUN, SR, CLR, NONE, NONE, NONE, NONE, NONE, NONE, NONE};
    @(negedge clk);
    rx_done = 1'b1;
    for (int i = 0; i <= s.len(); i++) begin
      rx_data = i < s.len() ? s[i] : 8'h0d;
      @(negedge clk);
      if (i < s.len()) begin
        checks++; if (p !== exp[i]) begin errors++; $display("FAIL b2b_%0d got %h want %h", i, p, exp[i]); end
      end
    end
    rx_done = 1'b0;
    checks++; if (p !== VAL || {set_hour, set_min, set_sec} !== {5'd1, 6'd2, 6'd3}) begin errors++; $display("FAIL b2b_time got %h %0d:%0d:%0d want %h 1:2:3", p, set_hour, set_min, set_sec, VAL); end
  endtask
  task automatic test_mid_reset;
    send_str("S1234");
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (p !== NONE || busy !== 1'b0) begin errors++; $display("FAIL mid_reset_%0d got %h busy %b want %h busy 0", i, p, busy, NONE); end
    end
    checks++; if ({set_hour, set_min, set_sec} !== 17'd0) begin errors++; $display("FAIL mid_reset_time got %0d:%0d:%0d want 0:0:0", set_hour, set_min, set_sec); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (p !== NONE || busy !== 1'b0) begin errors++; $display("FAIL post_reset got %h busy %b want %h busy 0", p, busy, NONE); end
    send_str("S000000");
    send(8'h0a);
    checks++; if (p !== VAL || {set_hour, set_min, set_sec} !== 17'd0) begin errors++; $display("FAIL post_reset_set got %h %0d:%0d:%0d want %h 0:0:0", p, set_hour, set_min, set_sec, VAL); end
  endtask
  initial begin
    test_reset;
    test_commands;
    test_lowercase;
    test_set_time;
    test_range;
    test_digit_err;
    test_back_to_back;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
